// File: rtl/debug_wb_serializer.sv
// debug_wb_serializer
//   Collects up to two register writebacks per cycle from a dual-issue core
//   and replays them one per cycle on a single debug trace port. Program
//   order is preserved: within a cycle lane 0 is older than lane 1.
//
// Ports
//   clk, resetn         clock, asynchronous active-low reset
//   wb0_*               commit lane 0 (older): en, rd, wdata, pc
//   wb1_*               commit lane 1 (younger): en, rd, wdata, pc
//   stall_req           registered request to hold writeback (2 slots headroom)
//   debug_wb_pc         serialized commit PC
//   debug_wb_rf_wen     4'hf while an entry is presented, else 0
//   debug_wb_rf_wnum    destination register of the presented entry
//   debug_wb_rf_wdata   write data of the presented entry
//   overflow            sticky: a lane write was lost since reset
//   occupancy           number of queued entries
//
// Handshake: a lane write is offered when wbN_en=1 and is taken in that same
// cycle; there is no ready. stall_req is the only back-pressure and is
// advisory: if the core ignores it and the FIFO cannot hold every offered
// write, the older write is kept, the rest are dropped and overflow is set.
// The trace port has no ready either: debug_wb_rf_wen=4'hf marks a valid beat.
module debug_wb_serializer #(
    parameter int DEPTH   = 8,
    parameter bit DROP_R0 = 1'b1
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     wb0_en,
    input  logic [4:0]               wb0_rd,
    input  logic [31:0]              wb0_wdata,
    input  logic [31:0]              wb0_pc,
    input  logic                     wb1_en,
    input  logic [4:0]               wb1_rd,
    input  logic [31:0]              wb1_wdata,
    input  logic [31:0]              wb1_pc,
    output logic                     stall_req,
    output logic [31:0]              debug_wb_pc,
    output logic [3:0]               debug_wb_rf_wen,
    output logic [4:0]               debug_wb_rf_wnum,
    output logic [31:0]              debug_wb_rf_wdata,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic [31:0] pc;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    logic            acc0;
    logic            acc1;
    logic            pop;
    logic            ovf_now;
    logic [OW-1:0]   free_cnt;
    logic [OW-1:0]   n_req;
    logic [OW-1:0]   n_push;
    logic [OW-1:0]   occ_next;
    entry_t          lane0_e;
    entry_t          lane1_e;
    entry_t          first_e;
    entry_t          head_e;

    always_comb begin
        acc0     = wb0_en && (!DROP_R0 || (wb0_rd != 5'd0));
        acc1     = wb1_en && (!DROP_R0 || (wb1_rd != 5'd0));
        lane0_e  = '{rd: wb0_rd, wdata: wb0_wdata, pc: wb0_pc};
        lane1_e  = '{rd: wb1_rd, wdata: wb1_wdata, pc: wb1_pc};
        pop      = (occupancy != '0);
        // The slot freed by this cycle's pop is reusable in the same cycle.
        free_cnt = OW'(DEPTH) - occupancy + OW'(pop);
        n_req    = OW'(acc0) + OW'(acc1);
        ovf_now  = (n_req > free_cnt);
        n_push   = ovf_now ? free_cnt : n_req;
        occ_next = occupancy + n_push - OW'(pop);
        // The oldest accepted write always takes the first free slot, so a
        // lane-1-only write lands where lane 0 would have gone.
        first_e  = acc0 ? lane0_e : lane1_e;
        head_e   = mem[rd_ptr];
    end

    // Payload storage needs no reset: occupancy alone says what is valid.
    always_ff @(posedge clk) begin
        if (n_push != '0) begin
            mem[wr_ptr] <= first_e;
        end
        if (n_push == OW'(2)) begin
            mem[wr_ptr + AW'(1)] <= lane1_e;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            occupancy         <= '0;
            stall_req         <= 1'b0;
            overflow          <= 1'b0;
            debug_wb_pc       <= '0;
            debug_wb_rf_wen   <= '0;
            debug_wb_rf_wnum  <= '0;
            debug_wb_rf_wdata <= '0;
        end else begin
            wr_ptr    <= wr_ptr + n_push[AW-1:0];
            rd_ptr    <= rd_ptr + AW'(pop);
            occupancy <= occ_next;
            // Raised early enough that the two commits already in flight
            // when the core sees it still fit.
            stall_req <= (occ_next > OW'(DEPTH - 3));
            overflow  <= overflow | ovf_now;
            if (pop) begin
                debug_wb_pc       <= head_e.pc;
                debug_wb_rf_wen   <= 4'hf;
                debug_wb_rf_wnum  <= head_e.rd;
                debug_wb_rf_wdata <= head_e.wdata;
            end else begin
                debug_wb_pc       <= '0;
                debug_wb_rf_wen   <= '0;
                debug_wb_rf_wnum  <= '0;
                debug_wb_rf_wdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_debug_wb_serializer.sv
module tb_debug_wb_serializer;

    localparam int DEPTH = 8;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    always #5 clk = ~clk;

    logic        wb0_en = 1'b0;
    logic [4:0]  wb0_rd = '0;
    logic [31:0] wb0_wdata = '0;
    logic [31:0] wb0_pc = '0;
    logic        wb1_en = 1'b0;
    logic [4:0]  wb1_rd = '0;
    logic [31:0] wb1_wdata = '0;
    logic [31:0] wb1_pc = '0;
    logic        stall_req;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
    logic        overflow;
    logic [3:0]  occupancy;

    debug_wb_serializer #(.DEPTH(DEPTH), .DROP_R0(1'b1)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .wb0_en            (wb0_en),
        .wb0_rd            (wb0_rd),
        .wb0_wdata         (wb0_wdata),
        .wb0_pc            (wb0_pc),
        .wb1_en            (wb1_en),
        .wb1_rd            (wb1_rd),
        .wb1_wdata         (wb1_wdata),
        .wb1_pc            (wb1_pc),
        .stall_req         (stall_req),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata),
        .overflow          (overflow),
        .occupancy         (occupancy)
    );

    // ---------------- reference model / scoreboard ----------------
    // Trace entry packed as {pc, rd, wdata}.
    logic [68:0] exp_q[$];
    int          model_occ   = 0;
    bit          exp_present = 1'b0;
    bit          exp_ovf     = 1'b0;
    bit          exp_stall   = 1'b0;
    bit          mon_en      = 1'b0;
    int          errors      = 0;
    int          checks      = 0;
    logic [31:0] next_pc     = 32'hbfc0_1000;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Advance the model by one clock edge given the lane inputs seen there.
    task automatic model_step(bit e0, logic [4:0] r0, logic [31:0] d0, logic [31:0] p0,
                              bit e1, logic [4:0] r1, logic [31:0] d1, logic [31:0] p1);
        logic [68:0] acc[$];
        int          pop, free, kept;
        if (e0 && r0 != 5'd0) acc.push_back({p0, r0, d0});
        if (e1 && r1 != 5'd0) acc.push_back({p1, r1, d1});
        pop         = (model_occ > 0) ? 1 : 0;
        exp_present = (pop == 1);
        free        = DEPTH - model_occ + pop;
        kept        = (acc.size() > free) ? free : acc.size();
        if (acc.size() > free) exp_ovf = 1'b1;
        for (int i = 0; i < kept; i++) exp_q.push_back(acc[i]);
        model_occ   = model_occ + kept - pop;
        exp_stall   = (model_occ > DEPTH - 3);
    endtask

    // ---------------- driver ----------------
    task automatic cycle(bit e0, logic [4:0] r0, logic [31:0] d0, logic [31:0] p0,
                         bit e1, logic [4:0] r1, logic [31:0] d1, logic [31:0] p1);
        wb0_en = e0; wb0_rd = r0; wb0_wdata = d0; wb0_pc = p0;
        wb1_en = e1; wb1_rd = r1; wb1_wdata = d1; wb1_pc = p1;
        @(posedge clk);
        model_step(e0, r0, d0, p0, e1, r1, d1, p1);
        #1;
        // Disabled lanes carry junk that must not leak into the trace.
        wb0_en = 1'b0; wb0_rd = 5'($urandom); wb0_pc = $urandom; wb0_wdata = $urandom;
        wb1_en = 1'b0; wb1_rd = 5'($urandom); wb1_pc = $urandom; wb1_wdata = $urandom;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic dual(int n);
        for (int i = 0; i < n; i++) begin
            cycle(1, 5'($urandom_range(1, 31)), $urandom, next_pc,
                  1, 5'($urandom_range(1, 31)), $urandom, next_pc + 32'd4);
            next_pc += 32'd8;
        end
    endtask

    task automatic pulse_reset();
        resetn = 1'b0;
        #1;
        chk("rst_wen",   64'(debug_wb_rf_wen),   64'h0);
        chk("rst_pc",    64'(debug_wb_pc),       64'h0);
        chk("rst_wnum",  64'(debug_wb_rf_wnum),  64'h0);
        chk("rst_wdata", 64'(debug_wb_rf_wdata), 64'h0);
        chk("rst_occ",   64'(occupancy),         64'h0);
        chk("rst_stall", 64'(stall_req),         64'h0);
        chk("rst_ovf",   64'(overflow),          64'h0);
        #2;
        resetn = 1'b1;
        exp_q.delete();
        model_occ   = 0;
        exp_present = 1'b0;
        exp_ovf     = 1'b0;
        exp_stall   = 1'b0;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            logic [68:0] e;
            e = '0;
            if (debug_wb_rf_wen != 4'h0 || exp_present) begin
                if (exp_q.size() != 0) e = exp_q.pop_front();
            end
            if (!exp_present) e = '0;
            chk("wen",   64'(debug_wb_rf_wen),   exp_present ? 64'hf : 64'h0);
            chk("pc",    64'(debug_wb_pc),       64'(e[68:37]));
            chk("wnum",  64'(debug_wb_rf_wnum),  64'(e[36:32]));
            chk("wdata", 64'(debug_wb_rf_wdata), 64'(e[31:0]));
            chk("occ",   64'(occupancy),         64'(model_occ));
            chk("stall", 64'(stall_req),         64'(exp_stall));
            chk("ovf",   64'(overflow),          64'(exp_ovf));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        #3;
        chk("init_wen", 64'(debug_wb_rf_wen), 64'h0);
        chk("init_occ", 64'(occupancy),       64'h0);
        #9;
        resetn = 1'b1;
        mon_en = 1'b1;

        // Single write, then idle.
        cycle(1, 5'd5, 32'h1234_5678, 32'hbfc0_0000, 0, 0, 0, 0);
        idle(3);
        // Dual write in one cycle.
        cycle(1, 5'd2, 32'haaaa_0002, 32'hbfc0_0010, 1, 5'd3, 32'hbbbb_0003, 32'hbfc0_0014);
        idle(3);
        // r0 write on lane 0 is dropped; lane 1 alone.
        cycle(1, 5'd0, 32'hdead_0000, 32'hbfc0_0020, 1, 5'd7, 32'h0000_0007, 32'hbfc0_0024);
        idle(2);
        // Lane-1-only write.
        cycle(0, 5'd9, 32'h0, 32'h0, 1, 5'd9, 32'h9999_9999, 32'hbfc0_0030);
        idle(2);
        // Three dual-write cycles, then drain.
        dual(3);
        idle(8);
        // Ignore stall: fill past full to force drops.
        dual(10);
        idle(12);
        // Reset with entries queued.
        dual(3);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        pulse_reset();
        idle(4);

        // Random traffic, mostly honouring stall_req.
        for (int i = 0; i < 400; i++) begin
            bit honour;
            bit e0, e1;
            honour = ($urandom_range(0, 9) != 0);
            e0 = ($urandom_range(0, 2) != 0);
            e1 = ($urandom_range(0, 2) != 0);
            if (honour && stall_req) begin
                e0 = 1'b0;
                e1 = 1'b0;
            end
            cycle(e0, 5'($urandom_range(0, 31)), $urandom, next_pc,
                  e1, 5'($urandom_range(0, 31)), $urandom, next_pc + 32'd4);
            next_pc += 32'd8;
            if (i == 200) pulse_reset();
        end
        idle(12);
        chk("drained", 64'(exp_q.size()), 64'h0);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
